// File: rtl/tcp_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing the SiTCP TCP TX byte port between
// N_SRC byte streams, each frame prefixed by {HDR_TAG, source}. Define TX_TRAILER_EN
// to append a two-byte payload length trailer after every frame.
module tcp_tx_arbiter #(
    parameter int         N_SRC   = 4,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tcp_open_ack,
    input  logic               tcp_tx_full,
    output logic               tcp_tx_wr,
    output logic [7:0]         tcp_txd,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_last,
    output logic [N_SRC-1:0]   src_ready,
    output logic [3:0]         grant_id,
    output logic               busy,
    output logic [15:0]        drop_cnt
);

    // Source handshake: a byte moves when src_valid[i] & src_ready[i] in the same cycle.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef TX_TRAILER_EN
    localparam logic [2:0] S_TRAIL = 3'd4;
`endif

    logic [2:0]   state_q, state_d;
    logic [3:0]   grant_q, grant_d;
    logic [3:0]   last_q, last_d;
    logic         wr_q, wr_d;
    logic [7:0]   txd_q, txd_d;
    logic [15:0]  drop_q, drop_d;
`ifdef TX_TRAILER_EN
    logic [15:0]  len_q, len_d;
    logic         trail_q, trail_d;
`endif

    logic [15:0]  valid_ext, last_ext, ready_ext;
    logic [127:0] data_ext;
    logic         can_send, cur_valid, cur_last;
    logic [7:0]   cur_data;
    logic         found;
    logic [3:0]   winner;
    logic [4:0]   scan_idx;

    // Widen the per-source buses to 16 so grant_q can index them for any N_SRC.
    assign valid_ext = 16'(src_valid);
    assign last_ext  = 16'(src_last);
    assign data_ext  = 128'(src_data);

    assign can_send  = tcp_open_ack & ~tcp_tx_full;
    assign cur_valid = valid_ext[grant_q];
    assign cur_last  = last_ext[grant_q];
    assign cur_data  = data_ext[{grant_q, 3'b000} +: 8];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        found    = 1'b0;
        winner   = last_q;
        scan_idx = 5'd0;
        for (int k = 1; k <= N_SRC; k++) begin
            scan_idx = 5'(last_q) + 5'(k);
            if (scan_idx >= 5'(N_SRC)) scan_idx = scan_idx - 5'(N_SRC);
            if (!found && valid_ext[scan_idx[3:0]]) begin
                found  = 1'b1;
                winner = scan_idx[3:0];
            end
        end
    end

    always_comb begin
        ready_ext = 16'd0;
        if (state_q == S_DATA)  ready_ext[grant_q] = can_send;
        if (state_q == S_DRAIN) ready_ext[grant_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wr_d    = 1'b0;
        txd_d   = txd_q;
        drop_d  = drop_q;
`ifdef TX_TRAILER_EN
        len_d   = len_q;
        trail_d = trail_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tcp_open_ack && found) begin
                    grant_d = winner;
                    last_d  = winner;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (can_send) begin
                    wr_d    = 1'b1;
                    txd_d   = {HDR_TAG, grant_q};
`ifdef TX_TRAILER_EN
                    len_d   = 16'd0;
`endif
                    state_d = S_DATA;
                end else if (!tcp_open_ack) begin
                    drop_d  = sat_inc(drop_q);
                    state_d = S_DRAIN;
                end
            end
            S_DATA: begin
                if (cur_valid && can_send) begin
                    wr_d  = 1'b1;
                    txd_d = cur_data;
`ifdef TX_TRAILER_EN
                    len_d = len_q + 16'd1;
                    if (cur_last) begin
                        trail_d = 1'b0;
                        state_d = S_TRAIL;
                    end
`else
                    if (cur_last) state_d = S_IDLE;
`endif
                end else if (!tcp_open_ack) begin
                    drop_d  = sat_inc(drop_q);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Swallow the rest of the frame so the requester never stalls.
                if (cur_valid && cur_last) state_d = S_IDLE;
            end
`ifdef TX_TRAILER_EN
            S_TRAIL: begin
                if (!tcp_open_ack) begin
                    drop_d  = sat_inc(drop_q);
                    state_d = S_IDLE;
                end else if (can_send) begin
                    wr_d    = 1'b1;
                    txd_d   = trail_q ? len_q[7:0] : len_q[15:8];
                    trail_d = 1'b1;
                    if (trail_q) state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 4'd0;
            last_q  <= 4'(N_SRC - 1);
            wr_q    <= 1'b0;
            txd_q   <= 8'd0;
            drop_q  <= 16'd0;
`ifdef TX_TRAILER_EN
            len_q   <= 16'd0;
            trail_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            txd_q   <= txd_d;
            drop_q  <= drop_d;
`ifdef TX_TRAILER_EN
            len_q   <= len_d;
            trail_q <= trail_d;
`endif
        end
    end

    assign tcp_tx_wr = wr_q;
    assign tcp_txd   = txd_q;
    assign src_ready = ready_ext[N_SRC-1:0];
    assign grant_id  = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: a table of single frames plus hand-built
// sequences for round-robin, backpressure, connection loss, reset and saturation.
`timescale 1ns/1ps
module tb_tcp_tx_arbiter;
  localparam int N = 4;
`ifdef TX_TRAILER_EN
  localparam int FRAME_EXTRA = 2;
`else
  localparam int FRAME_EXTRA = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           tcp_open_ack;
  logic           tcp_tx_full;
  logic           tcp_tx_wr;
  logic [7:0]     tcp_txd;
  logic [N-1:0]   src_valid;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_ready;
  logic [3:0]     grant_id;
  logic           busy;
  logic [15:0]    drop_cnt;

  tcp_tx_arbiter #(.N_SRC(N), .HDR_TAG(4'hA)) dut (
    .clk(clk), .rst(rst),
    .tcp_open_ack(tcp_open_ack), .tcp_tx_full(tcp_tx_full),
    .tcp_tx_wr(tcp_tx_wr), .tcp_txd(tcp_txd),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(src_ready), .grant_id(grant_id), .busy(busy), .drop_cnt(drop_cnt)
  );

  // clock / reset
  always #2 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  logic [7:0] exp_q[$];
  logic [8:0] sq[N][$];

  logic [N-1:0] snap_ready;
  logic         snap_wr, snap_busy;
  logic [7:0]   snap_txd;
  logic [3:0]   snap_grant;
  logic [15:0]  snap_drop;

  typedef struct {
    int         src;
    int         len;
    logic [7:0] base;
    logic [3:0] exp_grant;
    logic [7:0] exp_hdr;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive_srcs();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() > 0) begin
        e = sq[i][0];
        src_valid[i]       = 1'b1;
        src_data[8*i +: 8] = e[7:0];
        src_last[i]        = e[8];
      end else begin
        src_valid[i]       = 1'b0;
        src_data[8*i +: 8] = 8'd0;
        src_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: sample outputs and check writes on the falling edge, then advance sources.
  task automatic tick();
    logic [N-1:0] hs;
    logic [7:0]   e;
    @(negedge clk);
    snap_ready = src_ready;
    snap_wr    = tcp_tx_wr;
    snap_busy  = busy;
    snap_txd   = tcp_txd;
    snap_grant = grant_id;
    snap_drop  = drop_cnt;
    if (tcp_tx_wr) begin
      n_wr++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL txd_unexpected got %02h want no write", tcp_txd);
      end else begin
        e = exp_q.pop_front();
        if (tcp_txd !== e) begin
          n_fail++;
          $display("FAIL txd_byte got %02h want %02h", tcp_txd, e);
        end
      end
    end
    hs = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i] && sq[i].size() > 0) void'(sq[i].pop_front());
    drive_srcs();
  endtask

  task automatic push_frame(input int s, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++)
      sq[s].push_back({(k == n - 1) ? 1'b1 : 1'b0, 8'(int'(base) + k)});
  endtask

  task automatic expect_frame(input logic [7:0] hdr, input int n, input logic [7:0] base);
    logic [15:0] len;
    len = 16'(n);
    exp_q.push_back(hdr);
    for (int k = 0; k < n; k++) exp_q.push_back(8'(int'(base) + k));
`ifdef TX_TRAILER_EN
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
`else
    if (len == 16'd0) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) sq[i].delete();
    drive_srcs();
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) if (sq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input string name);
    int cnt;
    bit done;
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 3000) begin
      tick();
      cnt++;
      done = srcs_empty() && !snap_busy;
    end
    chk({name, "_timeout"}, 32'(done), 32'd1);
    tick();
    tick();
    chk({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_srcs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int n_wr0;
    int cnt;
    rst          = 1'b1;
    tcp_open_ack = 1'b1;
    tcp_tx_full  = 1'b0;
    src_valid    = '0;
    src_data     = '0;
    src_last     = '0;

    vt[0] = '{src: 1, len: 2, base: 8'h21, exp_grant: 4'd1, exp_hdr: 8'hA1};
    vt[1] = '{src: 3, len: 1, base: 8'h3C, exp_grant: 4'd3, exp_hdr: 8'hA3};
    vt[2] = '{src: 0, len: 4, base: 8'hF0, exp_grant: 4'd0, exp_hdr: 8'hA0};
    vt[3] = '{src: 2, len: 3, base: 8'h55, exp_grant: 4'd2, exp_hdr: 8'hA2};

    // reset state
    do_reset();
    chk("rst_wr", 32'(snap_wr), 32'd0);
    chk("rst_txd", 32'(snap_txd), 32'd0);
    chk("rst_ready", 32'(snap_ready), 32'd0);
    chk("rst_grant", 32'(snap_grant), 32'd0);
    chk("rst_busy", 32'(snap_busy), 32'd0);
    chk("rst_drop", 32'(snap_drop), 32'd0);

    // single frame 11,22,33 from source 0
    n_wr0 = n_wr;
    push_frame(0, 3, 8'h11);
    sq[0].delete();
    sq[0].push_back({1'b0, 8'h11});
    sq[0].push_back({1'b0, 8'h22});
    sq[0].push_back({1'b1, 8'h33});
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
`ifdef TX_TRAILER_EN
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
`endif
    drive_srcs();
    run_idle("single");
    chk("single_wr_cnt", 32'(n_wr - n_wr0), 32'(4 + FRAME_EXTRA));
    chk("single_busy", 32'(snap_busy), 32'd0);

    // table of isolated frames
    for (int v = 0; v < 4; v++) begin
      push_frame(vt[v].src, vt[v].len, vt[v].base);
      expect_frame(vt[v].exp_hdr, vt[v].len, vt[v].base);
      drive_srcs();
      run_idle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_grant", v), 32'(snap_grant), 32'(vt[v].exp_grant));
    end

    // round-robin: all sources hold two one-byte frames
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) begin
        push_frame(i, 1, 8'((i << 4) | j));
        expect_frame(8'(8'hA0 | i), 1, 8'((i << 4) | j));
      end
    drive_srcs();
    run_idle("rr");

    // backpressure for 5 cycles in the middle of an 8-byte frame
    push_frame(0, 8, 8'h80);
    expect_frame(8'hA0, 8, 8'h80);
    drive_srcs();
    for (int c = 0; c < 4; c++) tick();
    tcp_tx_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_ready%0d", c), 32'(snap_ready), 32'd0);
      if (c > 0) chk($sformatf("bp_wr%0d", c), 32'(snap_wr), 32'd0);
    end
    tcp_tx_full = 1'b0;
    run_idle("bp");

    // connection lost after 2 of 6 bytes
    push_frame(1, 6, 8'h60);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h60);
    exp_q.push_back(8'h61);
    drive_srcs();
    for (int c = 0; c < 4; c++) tick();
    tcp_open_ack = 1'b0;
    cnt = 0;
    while (sq[1].size() != 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("drain_consumed", 32'(sq[1].size()), 32'd0);
    tick();
    tick();
    chk("drop_after_abort", 32'(snap_drop), 32'd1);
    chk("drop_sb_left", 32'(exp_q.size()), 32'd0);
    push_frame(1, 3, 8'h70);
    drive_srcs();
    for (int c = 0; c < 6; c++) tick();
    chk("held_busy", 32'(snap_busy), 32'd0);
    chk("held_queue", 32'(sq[1].size()), 32'd3);
    tcp_open_ack = 1'b1;
    expect_frame(8'hA1, 3, 8'h70);
    run_idle("reconnect");

    // reset during DATA
    push_frame(2, 6, 8'h90);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h91);
    drive_srcs();
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_srcs();
    tick();
    chk("mid_rst_wr", 32'(snap_wr), 32'd0);
    chk("mid_rst_txd", 32'(snap_txd), 32'd0);
    chk("mid_rst_ready", 32'(snap_ready), 32'd0);
    chk("mid_rst_grant", 32'(snap_grant), 32'd0);
    chk("mid_rst_busy", 32'(snap_busy), 32'd0);
    chk("mid_rst_drop", 32'(snap_drop), 32'd0);
    chk("mid_rst_sb_left", 32'(exp_q.size()), 32'd0);
    push_frame(3, 1, 8'hC0);
    push_frame(0, 1, 8'hD0);
    expect_frame(8'hA0, 1, 8'hD0);
    expect_frame(8'hA3, 1, 8'hC0);
    drive_srcs();
    run_idle("post_rst");
    chk("post_rst_grant", 32'(snap_grant), 32'd3);

    // drop counter saturation
    force dut.drop_q = 16'hFFFF;
    tick();
    release dut.drop_q;
    tick();
    chk("sat_preset", 32'(snap_drop), 32'hFFFF);
    push_frame(0, 2, 8'hE0);
    drive_srcs();
    tick();
    tcp_open_ack = 1'b0;
    cnt = 0;
    while (sq[0].size() != 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("sat_drain", 32'(sq[0].size()), 32'd0);
    tick();
    chk("sat_hold", 32'(snap_drop), 32'hFFFF);
    tcp_open_ack = 1'b1;
    tick();
    tick();
    chk("sat_sb_left", 32'(exp_q.size()), 32'd0);

`ifdef TX_TRAILER_EN
    // 300-byte frame carries trailer 01,2C
    push_frame(1, 300, 8'h00);
    expect_frame(8'hA1, 300, 8'h00);
    drive_srcs();
    run_idle("len300");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
